wb_byte_ram: RTL

Parametrised on-chip RAM slave for the Wishbone peripheral fabric, the successor to the fixed 4096x32 byte-enable RAM. It adds:
- configurable data width and depth
- an optional output register
- a hardware init sequencer (zero-fill or index-fill) after reset
- a Wishbone classic slave handshake with ack, abort and out-of-range handling

It sits directly on the wbc_per bus as instruction/data scratch memory.

---
 rtl/wb_ram_pkg.sv | 21 ++
 rtl/byte_ram_core.sv | 29 ++
 rtl/wb_byte_ram.sv | 119 +++++++++++
 3 files changed

// File: rtl/wb_ram_pkg.sv
// Shared types and helpers for the Wishbone byte-enable RAM slave.
package wb_ram_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT
  } state_e;

  typedef enum logic [1:0] {
    INIT_NONE  = 2'd0,
    INIT_ZERO  = 2'd1,
    INIT_INDEX = 2'd2
  } init_mode_e;

  // Number of byte lanes in a data word.
  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/byte_ram_core.sv
// Byte-lane RAM array with per-byte write enables and a registered,
// read-enabled output port. No reset on storage so it maps onto block RAM.
module byte_ram_core
  import wb_ram_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH),
  parameter int NB    = lane_count(DW)
) (
  input  logic          clk,
  input  logic [NB-1:0] we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [NB-1:0][7:0] mem [DEPTH];

  // Per-lane writes and a read register that only moves when a read is issued.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (we[k]) mem[addr][k] <= wdata[8*k +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_byte_ram.sv
// Wishbone classic slave RAM: init sequencer, bus handshake, out-of-range
// handling and an optional output register stage around byte_ram_core.
module wb_byte_ram
  import wb_ram_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DEPTH     = 4096,
  parameter int AW        = $clog2(DEPTH),
  parameter int OUT_REG   = 0,
  parameter int INIT_MODE = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           adr_i,
  input  logic [lane_count(DW)-1:0] sel_i,
  input  logic [DW-1:0]           dat_i,
  output logic [DW-1:0]           dat_o,
  output logic                    ack_o,
  output logic                    init_busy_o
);

  localparam int         NB          = lane_count(DW);
  localparam init_mode_e MODE        = init_mode_e'(INIT_MODE);
  localparam state_e     RESET_STATE = (MODE != INIT_NONE) ? S_INIT : S_IDLE;
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

  state_e        state, state_next;
  logic [AW-1:0] init_ptr;
  logic          ack_q, ack_next;
  logic          rd_zero_q;
  logic [DW-1:0] dat_q;

  logic          accept;
  logic          oor;
  logic [NB-1:0] core_we;
  logic          core_re;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;

  assign oor = ({1'b0, adr_i} >= DEPTH_EXT);

  // Next-state, handshake and RAM port steering; init owns the port while busy.
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    accept     = 1'b0;
    core_we    = '0;
    core_re    = 1'b0;
    core_addr  = adr_i;
    core_wdata = dat_i;
    case (state)
      S_INIT: begin
        core_addr  = init_ptr;
        core_we    = '1;
        core_wdata = (MODE == INIT_INDEX) ? DW'(init_ptr) : '0;
        if (init_ptr == LAST) state_next = S_IDLE;
      end
      S_IDLE: begin
        accept = cyc_i & stb_i & ~ack_q;
        if (accept) begin
          if (we_i) begin
            core_we  = oor ? '0 : sel_i;
            ack_next = 1'b1;
          end else begin
            core_re = ~oor;
            if (OUT_REG != 0) state_next = S_RD_WAIT;
            else ack_next = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        ack_next   = cyc_i;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, init pointer, ack pulse and read-result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RESET_STATE;
      init_ptr  <= '0;
      ack_q     <= 1'b0;
      rd_zero_q <= 1'b1;
      dat_q     <= '0;
    end else begin
      state <= state_next;
      ack_q <= ack_next;
      if (state == S_INIT) init_ptr <= (init_ptr == LAST) ? '0 : init_ptr + 1'b1;
      if (accept && !we_i) rd_zero_q <= oor;
      if (state == S_RD_WAIT && cyc_i) dat_q <= rd_zero_q ? '0 : core_rdata;
    end
  end

  byte_ram_core #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .NB    (NB)
  ) u_core (
    .clk   (clk_i),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  assign dat_o       = (OUT_REG != 0) ? dat_q : (rd_zero_q ? '0 : core_rdata);
  assign ack_o       = ack_q;
  assign init_busy_o = (state == S_INIT);

endmodule
